// File: rtl/rgb_to_grayscale_pkg.sv
// Shared colour-conversion constants: luma weight sets and the component index
// used to locate B/G/R fields inside a packed RGB word.
package rgb_to_grayscale_pkg;

    localparam int unsigned COEF_FRAC = 8;

    localparam int unsigned BT601_R_COEF = 77;
    localparam int unsigned BT601_G_COEF = 150;
    localparam int unsigned BT601_B_COEF = 29;

    localparam int unsigned BT709_R_COEF = 54;
    localparam int unsigned BT709_G_COEF = 183;
    localparam int unsigned BT709_B_COEF = 19;

    // Position of each component in a packed RGB word, counted in PX_WIDTH slots.
    typedef enum logic [1:0] {
        COMP_B = 2'd0,
        COMP_G = 2'd1,
        COMP_R = 2'd2
    } comp_idx_e;

endpackage

// File: rtl/axi4_stream_if.sv
// AXI4-Stream bundle with master/slave views; tuser carries start of frame,
// tlast carries end of line.
interface axi4_stream_if #(
    parameter int DATA_W = 32,
    parameter int DEST_W = 4,
    parameter int ID_W   = 4
) ();
    logic [DATA_W-1:0]   tdata;
    logic [DATA_W/8-1:0] tstrb;
    logic [DATA_W/8-1:0] tkeep;
    logic                tvalid;
    logic                tready;
    logic                tlast;
    logic                tuser;
    logic [DEST_W-1:0]   tdest;
    logic [ID_W-1:0]     tid;

    modport master (
        output tdata, tstrb, tkeep, tvalid, tlast, tuser, tdest, tid,
        input  tready
    );

    modport slave (
        input  tdata, tstrb, tkeep, tvalid, tlast, tuser, tdest, tid,
        output tready
    );
endinterface

// File: rtl/rgb_to_grayscale.sv
// RGB to luma converter: weighted sum of R/G/B in three enable-gated register
// stages, sideband travelling in lockstep, stalls whenever the output is held.
module rgb_to_grayscale
    import rgb_to_grayscale_pkg::*;
#(
    parameter int unsigned PX_WIDTH   = 10,
    parameter int unsigned R_COEF     = BT601_R_COEF,
    parameter int unsigned G_COEF     = BT601_G_COEF,
    parameter int unsigned B_COEF     = BT601_B_COEF,
    parameter int unsigned COEF_FRAC  = rgb_to_grayscale_pkg::COEF_FRAC,
    parameter int unsigned OUT_DATA_W = 16,
    parameter int unsigned DEST_W     = 4,
    parameter int unsigned ID_W       = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    axi4_stream_if.slave  video_i,
    axi4_stream_if.master video_o
);

    localparam int unsigned PROD_W = PX_WIDTH + COEF_FRAC;
    localparam int unsigned SUM_W  = PROD_W + 2;
    localparam int unsigned SHR_W  = SUM_W - COEF_FRAC;
    localparam int unsigned STRB_W = OUT_DATA_W / 8;
    localparam logic [SUM_W-1:0] ROUND  = SUM_W'(2 ** (COEF_FRAC - 1));
    localparam logic [SHR_W-1:0] PX_MAX = SHR_W'(2 ** PX_WIDTH - 1);

    if (R_COEF + G_COEF + B_COEF != 2 ** COEF_FRAC) begin : g_coef_check
        $error("rgb_to_grayscale: R_COEF+G_COEF+B_COEF must equal 2**COEF_FRAC");
    end

    logic                en;
    logic [PROD_W-1:0]   prod_in [3];
    logic [SHR_W-1:0]    shr;

    logic                valid_q [3];
    logic                valid_d [3];
    logic                user_q  [3];
    logic                user_d  [3];
    logic                last_q  [3];
    logic                last_d  [3];
    logic [DEST_W-1:0]   dest_q  [3];
    logic [DEST_W-1:0]   dest_d  [3];
    logic [ID_W-1:0]     id_q    [3];
    logic [ID_W-1:0]     id_d    [3];
    logic [PROD_W-1:0]   prod_q  [3];
    logic [PROD_W-1:0]   prod_d  [3];
    logic [SUM_W-1:0]    sum_q;
    logic [SUM_W-1:0]    sum_d;
    logic [PX_WIDTH-1:0] y_q;
    logic [PX_WIDTH-1:0] y_d;
    logic [STRB_W-1:0]   strb_q;
    logic [STRB_W-1:0]   strb_d;

    // Upstream is stalled on any output hold, even if earlier slots are bubbles.
    assign en             = !valid_q[2] || video_o.tready;
    assign video_i.tready = en;

    for (genvar gi = 0; gi < 3; gi++) begin : g_mul
        localparam comp_idx_e   COMP = comp_idx_e'(gi);
        localparam int unsigned WGT  = (COMP == COMP_R) ? R_COEF :
                                       (COMP == COMP_G) ? G_COEF : B_COEF;
        assign prod_in[gi] = PROD_W'(video_i.tdata[gi*PX_WIDTH +: PX_WIDTH]) * PROD_W'(WGT);
    end

    assign shr = sum_q[SUM_W-1:COEF_FRAC];

    always_comb begin
        valid_d = valid_q;
        user_d  = user_q;
        last_d  = last_q;
        dest_d  = dest_q;
        id_d    = id_q;
        prod_d  = prod_q;
        sum_d   = sum_q;
        y_d     = y_q;
        strb_d  = strb_q;
        if (en) begin
            valid_d[0] = video_i.tvalid;
            user_d[0]  = video_i.tuser;
            last_d[0]  = video_i.tlast;
            dest_d[0]  = video_i.tdest;
            id_d[0]    = video_i.tid;
            for (int i = 1; i < 3; i++) begin
                valid_d[i] = valid_q[i-1];
                user_d[i]  = user_q[i-1];
                last_d[i]  = last_q[i-1];
                dest_d[i]  = dest_q[i-1];
                id_d[i]    = id_q[i-1];
            end
            prod_d = prod_in;
            sum_d  = SUM_W'(prod_q[0]) + SUM_W'(prod_q[1]) + SUM_W'(prod_q[2]) + ROUND;
            // Unreachable with weights summing to one, kept as an overflow guard.
            y_d    = (shr > PX_MAX) ? '1 : shr[PX_WIDTH-1:0];
            strb_d = '1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '{default: 1'b0};
            user_q  <= '{default: 1'b0};
            last_q  <= '{default: 1'b0};
            dest_q  <= '{default: '0};
            id_q    <= '{default: '0};
            prod_q  <= '{default: '0};
            sum_q   <= '0;
            y_q     <= '0;
            strb_q  <= '0;
        end else begin
            valid_q <= valid_d;
            user_q  <= user_d;
            last_q  <= last_d;
            dest_q  <= dest_d;
            id_q    <= id_d;
            prod_q  <= prod_d;
            sum_q   <= sum_d;
            y_q     <= y_d;
            strb_q  <= strb_d;
        end
    end

    assign video_o.tvalid = valid_q[2];
    assign video_o.tdata  = OUT_DATA_W'(y_q);
    assign video_o.tuser  = user_q[2];
    assign video_o.tlast  = last_q[2];
    assign video_o.tdest  = dest_q[2];
    assign video_o.tid    = id_q[2];
    assign video_o.tstrb  = strb_q;
    assign video_o.tkeep  = strb_q;

    logic unused_in;
    assign unused_in = ^{video_i.tdata, video_i.tstrb, video_i.tkeep};

endmodule

// File: tb/tb_rgb_to_grayscale.sv
// Directed and randomised checks of rgb_to_grayscale: luma values, latency,
// sideband alignment, backpressure stability, mid-stream reset, BT.709 weights.
module tb_rgb_to_grayscale;
    import rgb_to_grayscale_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    axi4_stream_if #(.DATA_W(32), .DEST_W(4), .ID_W(4)) in_if ();
    axi4_stream_if #(.DATA_W(16), .DEST_W(4), .ID_W(4)) out_if ();
    axi4_stream_if #(.DATA_W(32), .DEST_W(4), .ID_W(4)) in709 ();
    axi4_stream_if #(.DATA_W(16), .DEST_W(4), .ID_W(4)) out709 ();

    rgb_to_grayscale u_dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .video_i (in_if),
        .video_o (out_if)
    );

    rgb_to_grayscale #(
        .R_COEF (BT709_R_COEF),
        .G_COEF (BT709_G_COEF),
        .B_COEF (BT709_B_COEF)
    ) u_dut709 (
        .clk_i   (clk),
        .rst_i   (rst),
        .video_i (in709),
        .video_o (out709)
    );

    typedef struct packed {
        logic [15:0] y;
        logic        user;
        logic        last;
        logic [3:0]  dest;
        logic [3:0]  id;
    } beat_t;

    int     checks   = 0;
    int     failures = 0;
    int     cycle    = 0;
    int     beat_no  = 0;
    bit     chk_lat  = 1'b0;
    bit     rand_rdy = 1'b0;
    bit     accepted = 1'b0;
    bit     stalled_prev = 1'b0;
    beat_t  prev_out;
    beat_t  cur_exp;
    beat_t  exp_q [$];
    int     acc_q [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_y(input int r, input int g, input int b);
        int s;
        s = (r * 77 + g * 150 + b * 29 + 128) / 256;
        if (s > 1023) s = 1023;
        return 16'(s);
    endfunction

    function automatic beat_t out_beat();
        return '{y: out_if.tdata, user: out_if.tuser, last: out_if.tlast,
                 dest: out_if.tdest, id: out_if.tid};
    endfunction

    // One clock: called at a falling edge with inputs already driven.
    task automatic step();
        beat_t e;
        int    a;
        if (rand_rdy) out_if.tready = 1'($urandom_range(0, 1));
        #1;
        chk("ready_rule", 64'(in_if.tready), 64'(!out_if.tvalid || out_if.tready));
        if (stalled_prev) chk("stall_stable", 64'(out_beat()), 64'(prev_out));
        if (out_if.tvalid && out_if.tready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", 64'(out_beat()), 64'(0));
            end else begin
                e = exp_q.pop_front();
                a = acc_q.pop_front();
                $display("beat %0d: y=%0d user=%0b last=%0b dest=%0h id=%0h (exp y=%0d)",
                         beat_no, out_if.tdata, out_if.tuser, out_if.tlast,
                         out_if.tdest, out_if.tid, e.y);
                beat_no++;
                chk("beat", 64'(out_beat()), 64'(e));
                chk("tkeep_tstrb", 64'({out_if.tkeep, out_if.tstrb}), 64'(4'hF));
                if (chk_lat) chk("latency", 64'(cycle - a), 64'(3));
            end
        end
        accepted = in_if.tvalid && in_if.tready;
        if (accepted) begin
            exp_q.push_back(cur_exp);
            acc_q.push_back(cycle);
        end
        stalled_prev = out_if.tvalid && !out_if.tready;
        prev_out     = out_beat();
        @(posedge clk);
        @(negedge clk);
        cycle++;
    endtask

    task automatic send(input int r, input int g, input int b, input logic user,
                        input logic last, input logic [3:0] dest, input logic [3:0] id,
                        input logic [15:0] y);
        bit done = 1'b0;
        in_if.tdata  = {2'b00, 10'(r), 10'(g), 10'(b)};
        in_if.tuser  = user;
        in_if.tlast  = last;
        in_if.tdest  = dest;
        in_if.tid    = id;
        in_if.tvalid = 1'b1;
        cur_exp = '{y: y, user: user, last: last, dest: dest, id: id};
        for (int i = 0; i < 200 && !done; i++) begin
            step();
            done = accepted;
        end
        if (!done) chk("send_timeout", 64'(0), 64'(1));
        in_if.tvalid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 500 && exp_q.size() != 0; i++) step();
        chk("drain_empty", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        logic [3:0] r_dest;
        logic [3:0] r_id;
        logic       r_user;
        logic       r_last;
        int         r_r;
        int         r_g;
        int         r_b;

        in_if.tvalid = 1'b0; in_if.tdata = '0; in_if.tuser = 1'b0; in_if.tlast = 1'b0;
        in_if.tdest = '0; in_if.tid = '0; in_if.tstrb = '1; in_if.tkeep = '1;
        out_if.tready = 1'b0;
        in709.tvalid = 1'b0; in709.tdata = '0; in709.tuser = 1'b0; in709.tlast = 1'b0;
        in709.tdest = '0; in709.tid = '0; in709.tstrb = '1; in709.tkeep = '1;
        out709.tready = 1'b1;

        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_tvalid", 64'(out_if.tvalid), 64'(0));
        chk("reset_tdata", 64'(out_if.tdata), 64'(0));
        chk("reset_side", 64'({out_if.tuser, out_if.tlast, out_if.tdest, out_if.tid}), 64'(0));
        chk("reset_keep", 64'({out_if.tkeep, out_if.tstrb}), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        // Full scale, zero and single-channel weights at full throughput.
        out_if.tready = 1'b1;
        chk_lat = 1'b1;
        send(1023, 1023, 1023, 1'b0, 1'b0, 4'h0, 4'h0, 16'd1023);
        send(0, 0, 0, 1'b0, 1'b0, 4'h0, 4'h0, 16'd0);
        send(1023, 0, 0, 1'b0, 1'b0, 4'h1, 4'h2, 16'd308);
        send(0, 1023, 0, 1'b0, 1'b0, 4'h2, 4'h3, 16'd599);
        send(0, 0, 1023, 1'b0, 1'b0, 4'h3, 4'h4, 16'd116);
        send(512, 512, 512, 1'b0, 1'b0, 4'h4, 4'h5, 16'd512);
        drain();

        // 4x2 frame: sof on pixel 0, eol on pixels 3 and 7.
        for (int p = 0; p < 8; p++)
            send(p * 100, p * 100, p * 100, p == 0, (p % 4) == 3,
                 4'(p), 4'(15 - p), 16'(p * 100));
        drain();

        // BT.709 instance: pure red full scale.
        in709.tdata  = {2'b00, 10'd1023, 10'd0, 10'd0};
        in709.tvalid = 1'b1;
        @(negedge clk);
        in709.tvalid = 1'b0;
        repeat (2) @(negedge clk);
        chk("bt709_tvalid", 64'(out709.tvalid), 64'(1));
        chk("bt709_red", 64'(out709.tdata), 64'(216));
        @(negedge clk);

        // Random stream with input gaps and 50% output backpressure.
        chk_lat  = 1'b0;
        rand_rdy = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            while ($urandom_range(0, 3) == 0) step();
            r_r = int'($urandom_range(0, 1023));
            r_g = int'($urandom_range(0, 1023));
            r_b = int'($urandom_range(0, 1023));
            r_user = 1'($urandom_range(0, 1));
            r_last = 1'($urandom_range(0, 1));
            r_dest = 4'($urandom_range(0, 15));
            r_id   = 4'($urandom_range(0, 15));
            send(r_r, r_g, r_b, r_user, r_last, r_dest, r_id, ref_y(r_r, r_g, r_b));
        end
        drain();
        rand_rdy = 1'b0;
        out_if.tready = 1'b1;

        // Reset with three beats in flight, then resume.
        chk_lat = 1'b1;
        send(300, 300, 300, 1'b1, 1'b0, 4'h7, 4'h7, 16'd300);
        send(301, 301, 301, 1'b0, 1'b0, 4'h7, 4'h7, 16'd301);
        send(302, 302, 302, 1'b0, 1'b1, 4'h7, 4'h7, 16'd302);
        rst = 1'b1;
        #1;
        chk("midrst_tvalid", 64'(out_if.tvalid), 64'(0));
        chk("midrst_tdata", 64'(out_if.tdata), 64'(0));
        chk("midrst_side", 64'({out_if.tuser, out_if.tlast, out_if.tdest, out_if.tid}), 64'(0));
        chk("midrst_keep", 64'({out_if.tkeep, out_if.tstrb}), 64'(0));
        exp_q.delete();
        acc_q.delete();
        stalled_prev = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        send(100, 100, 100, 1'b0, 1'b0, 4'h0, 4'h0, 16'd100);
        drain();
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
